// File: rtl/ahb_req_master_if.sv
// Request/response stream and AHB3-Lite bus bundle for ahb_req_master.
// The master modport is the initiator's view; slave is the requester/bus-slave side.
interface ahb_req_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_wdata_i;

  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  logic [31:0] m_haddr_o;
  logic        m_hwrite_o;
  logic [2:0]  m_hsize_o;
  logic [1:0]  m_htrans_o;
  logic [2:0]  m_hburst_o;
  logic        m_hmastlock_o;
  logic [3:0]  m_hprot_o;
  logic [31:0] m_hwdata_o;
  logic [5:0]  m_hparity_o;
  logic [31:0] m_hrdata_i;
  logic        m_hready_i;
  logic        m_hresp_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
    input  m_hrdata_i, m_hready_i, m_hresp_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output m_haddr_o, m_hwrite_o, m_hsize_o, m_htrans_o, m_hburst_o,
    output m_hmastlock_o, m_hprot_o, m_hwdata_o, m_hparity_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
    output m_hrdata_i, m_hready_i, m_hresp_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  m_haddr_o, m_hwrite_o, m_hsize_o, m_htrans_o, m_hburst_o,
    input  m_hmastlock_o, m_hprot_o, m_hwdata_o, m_hparity_o
  );
endinterface

// File: rtl/ahb_req_master.sv
// AHB3-Lite single-transfer initiator: valid/ready requests in, in-order responses out.
// Optional address-phase parity is enabled by defining AHB_MASTER_IFP_EN.
module ahb_req_master #(
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic              s_clk_i,
  input  logic              s_resetn_i,
  ahb_req_master_if.master  bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q,  a_addr_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q,  a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        a_mis_q,   a_mis_d;

  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        d_mis_q,   d_mis_d;

  logic err_first;
  logic a_issue;
  logic a_adv;
  logic d_ret;
  logic req_ready;
  logic req_take;
  logic rsp_err;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      3'd0:    mis = 1'b0;
      3'd1:    mis = lsb[0];
      3'd2:    mis = |lsb;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // The first cycle of a two-cycle error response must see IDLE on the bus.
  assign err_first = bus.m_hresp_i & ~bus.m_hready_i;
  assign a_issue   = a_valid_q & ~a_mis_q & ~err_first;
  assign a_adv     = a_valid_q & bus.m_hready_i & (a_issue | a_mis_q);
  assign d_ret     = d_valid_q & bus.m_hready_i;
  assign req_ready = ~a_valid_q | (bus.m_hready_i & ~err_first);
  assign req_take  = bus.req_valid_i & req_ready;

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    a_mis_d   = a_mis_q;
    if (req_take) begin
      a_valid_d = 1'b1;
      a_addr_d  = bus.req_addr_i;
      a_write_d = bus.req_write_i;
      a_size_d  = bus.req_size_i;
      a_wdata_d = bus.req_wdata_i;
      a_mis_d   = is_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
  end

  // D only ever loads when the bus is ready, so it is retiring or empty at that point.
  always_comb begin
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    d_mis_d   = d_mis_q;
    if (a_adv) begin
      d_valid_d = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
      d_mis_d   = a_mis_q;
    end else if (d_ret) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      a_mis_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      d_mis_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q  <= a_addr_d;
      a_write_q <= a_write_d;
      a_size_q  <= a_size_d;
      a_wdata_q <= a_wdata_d;
      a_mis_q   <= a_mis_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      d_mis_q   <= d_mis_d;
    end
  end

  assign rsp_err = d_ret & (bus.m_hresp_i | d_mis_q);

  assign bus.req_ready_o   = req_ready;
  assign bus.rsp_valid_o   = d_ret;
  assign bus.rsp_err_o     = rsp_err;
  assign bus.rsp_rdata_o   = (d_ret & ~d_write_q & ~rsp_err) ? bus.m_hrdata_i : 32'h0;

  assign bus.m_haddr_o     = a_valid_q ? a_addr_q : RESET_ADDR;
  assign bus.m_hwrite_o    = a_valid_q & a_write_q;
  assign bus.m_hsize_o     = a_valid_q ? a_size_q : 3'b000;
  assign bus.m_htrans_o    = a_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.m_hburst_o    = 3'b000;
  assign bus.m_hmastlock_o = 1'b0;
  assign bus.m_hprot_o     = 4'b0011;
  assign bus.m_hwdata_o    = (d_valid_q & d_write_q) ? d_wdata_q : 32'h0;

`ifdef AHB_MASTER_IFP_EN
  assign bus.m_hparity_o = {^bus.m_htrans_o,
                            ^{bus.m_hwrite_o, bus.m_hsize_o},
                            ^bus.m_haddr_o[31:24],
                            ^bus.m_haddr_o[23:16],
                            ^bus.m_haddr_o[15:8],
                            ^bus.m_haddr_o[7:0]};
`else
  assign bus.m_hparity_o = 6'b0;
`endif

endmodule

// File: tb/tb_ahb_req_master.sv
// Self-checking bench for ahb_req_master: directed scenarios plus randomized traffic
// against a transaction-level scoreboard and a behavioural AHB slave.
module tb_ahb_req_master;

  localparam logic [31:0] RESET_ADDR = 32'hFFFF_0000;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          mis;
    int          waits;
    bit          err;
    bit          errSeen;
    int          expLat;
    int          accCycle;
  } txn_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ahb_req_master_if ifc();

  ahb_req_master #(.RESET_ADDR(RESET_ADDR)) dut (
    .s_clk_i    (clk),
    .s_resetn_i (rstn),
    .bus        (ifc)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  bit   randGaps = 1'b0;
  txn_t stimQ[$];
  txn_t rspQ[$];
  txn_t busQ[$];
  txn_t dataQ[$];

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // A transfer is misaligned when its address is not a multiple of its size in bytes.
  function automatic bit misModel(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd2) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] memVal(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [5:0] expParity(input logic [1:0] t, input logic w,
                                           input logic [2:0] s, input logic [31:0] a);
    logic [5:0] p;
    p = 6'b0;
`ifdef AHB_MASTER_IFP_EN
    for (int i = 0; i < 4; i++) p[i] = ^a[8*i +: 8];
    p[4] = ^{w, s};
    p[5] = ^t;
`endif
    return p;
  endfunction

  task automatic addRequest(input logic [31:0] addr, input logic write, input logic [2:0] size,
                            input logic [31:0] wdata, input int waits, input bit err, input int expLat);
    txn_t t;
    t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
    t.mis = 1'b0; t.waits = waits; t.err = err; t.errSeen = 1'b0;
    t.expLat = expLat; t.accCycle = 0;
    stimQ.push_back(t);
  endtask

  // Drives the next request and the slave's response for the coming cycle.
  task automatic applyStimulus();
    txn_t f;
    if (stimQ.size() != 0 && !(randGaps && $urandom_range(0, 3) == 0)) begin
      ifc.req_valid_i = 1'b1;
      ifc.req_addr_i  = stimQ[0].addr;
      ifc.req_write_i = stimQ[0].write;
      ifc.req_size_i  = stimQ[0].size;
      ifc.req_wdata_i = stimQ[0].wdata;
    end else begin
      ifc.req_valid_i = 1'b0;
      ifc.req_addr_i  = $urandom;
      ifc.req_write_i = 1'($urandom_range(0, 1));
      ifc.req_size_i  = 3'($urandom_range(0, 7));
      ifc.req_wdata_i = $urandom;
    end
    ifc.m_hrdata_i = $urandom;
    ifc.m_hready_i = 1'b1;
    ifc.m_hresp_i  = 1'b0;
    if (dataQ.size() != 0) begin
      f = dataQ[0];
      if (f.waits > 0) begin
        ifc.m_hready_i = 1'b0;
      end else if (f.err && !f.errSeen) begin
        ifc.m_hready_i = 1'b0;
        ifc.m_hresp_i  = 1'b1;
      end else if (f.err) begin
        ifc.m_hresp_i = 1'b1;
      end else if (!f.write) begin
        ifc.m_hrdata_i = memVal(f.addr);
      end
    end
  endtask

  task automatic stepCycle();
    txn_t t;
    txn_t f;
    bit accepted, completing, sHready, sHresp;
    logic [1:0] sTrans;
    @(negedge clk);
    cycle++;
    sHready    = ifc.m_hready_i;
    sHresp     = ifc.m_hresp_i;
    sTrans     = ifc.m_htrans_o;
    accepted   = ifc.req_valid_i && ifc.req_ready_o;
    completing = (dataQ.size() != 0) && sHready;

    if (sHresp && !sHready) checkOutput("htrans_err_idle", 32'(sTrans), 32'h0);
    if (sTrans == 2'b10) begin
      if (busQ.size() == 0) begin
        checkOutput("spurious_nonseq", 32'(sTrans), 32'h0);
      end else begin
        t = busQ[0];
        checkOutput("haddr", ifc.m_haddr_o, t.addr);
        checkOutput("hwrite", 32'(ifc.m_hwrite_o), 32'(t.write));
        checkOutput("hsize", 32'(ifc.m_hsize_o), 32'(t.size));
        checkOutput("hparity", 32'(ifc.m_hparity_o), 32'(expParity(2'b10, t.write, t.size, t.addr)));
        checkOutput("hctrl", {21'h0, ifc.m_hburst_o, ifc.m_hmastlock_o, 3'h0, ifc.m_hprot_o}, 32'h3);
      end
    end else begin
      checkOutput("htrans", 32'(sTrans), 32'h0);
    end
    if (rspQ.size() == 0) begin
      checkOutput("idle_haddr", ifc.m_haddr_o, RESET_ADDR);
      checkOutput("idle_hwdata", ifc.m_hwdata_o, 32'h0);
      checkOutput("idle_ready", 32'(ifc.req_ready_o), 32'h1);
    end
    if (dataQ.size() != 0 && dataQ[0].write) checkOutput("hwdata", ifc.m_hwdata_o, dataQ[0].wdata);

    if (completing) checkOutput("rsp_valid", 32'(ifc.rsp_valid_o), 32'h1);
    if (ifc.rsp_valid_o && rspQ.size() == 0) begin
      checkOutput("rsp_unexpected", 32'(ifc.rsp_valid_o), 32'h0);
    end else if (ifc.rsp_valid_o) begin
      t = rspQ.pop_front();
      if (t.mis) begin
        checkOutput("mis_err", 32'(ifc.rsp_err_o), 32'h1);
        checkOutput("mis_rdata", ifc.rsp_rdata_o, 32'h0);
        checkOutput("mis_order", 32'(completing), 32'h0);
      end else if (completing) begin
        checkOutput("rsp_addr", t.addr, dataQ[0].addr);
        checkOutput("rsp_err", 32'(ifc.rsp_err_o), 32'(dataQ[0].err));
        checkOutput("rsp_rdata", ifc.rsp_rdata_o,
                    (dataQ[0].write || dataQ[0].err) ? 32'h0 : memVal(dataQ[0].addr));
      end else begin
        checkOutput("rsp_early", 32'(completing), 32'h1);
      end
      if (t.expLat >= 0) checkOutput("latency", 32'(cycle - t.accCycle), 32'(t.expLat));
    end

    @(posedge clk);
    if (completing) begin
      void'(dataQ.pop_front());
    end else if (dataQ.size() != 0) begin
      f = dataQ[0];
      if (f.waits > 0) f.waits--;
      else if (f.err) f.errSeen = 1'b1;
      dataQ[0] = f;
    end
    if (sTrans == 2'b10 && sHready && busQ.size() != 0) dataQ.push_back(busQ.pop_front());
    if (accepted && stimQ.size() != 0) begin
      t = stimQ.pop_front();
      t.mis = misModel(t.size, t.addr);
      t.accCycle = cycle;
      rspQ.push_back(t);
      if (!t.mis) busQ.push_back(t);
      checkOutput("inflight", 32'(rspQ.size() <= 2), 32'h1);
    end
    #1;
    applyStimulus();
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n = 0;
    while ((stimQ.size() != 0 || rspQ.size() != 0) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    if (stimQ.size() != 0 || rspQ.size() != 0) begin
      checkOutput("drain_timeout", 32'(stimQ.size() + rspQ.size()), 32'h0);
      stimQ.delete(); rspQ.delete(); busQ.delete(); dataQ.delete();
    end
    repeat (2) stepCycle();
  endtask

  // Asserts reset asynchronously; in-flight transfers are dropped from the model too.
  task automatic doReset();
    rstn = 1'b0;
    stimQ.delete(); rspQ.delete(); busQ.delete(); dataQ.delete();
    ifc.req_valid_i = 1'b0;
    ifc.m_hready_i  = 1'b1;
    ifc.m_hresp_i   = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(ifc.req_ready_o), 32'h1);
    checkOutput("rst_rsp_valid", 32'(ifc.rsp_valid_o), 32'h0);
    checkOutput("rst_rsp_rdata", ifc.rsp_rdata_o, 32'h0);
    checkOutput("rst_rsp_err", 32'(ifc.rsp_err_o), 32'h0);
    checkOutput("rst_htrans", 32'(ifc.m_htrans_o), 32'h0);
    checkOutput("rst_haddr", ifc.m_haddr_o, RESET_ADDR);
    checkOutput("rst_hwdata", ifc.m_hwdata_o, 32'h0);
    checkOutput("rst_hparity", 32'(ifc.m_hparity_o), 32'(expParity(2'b00, 1'b0, 3'b000, RESET_ADDR)));
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    ifc.req_valid_i = 1'b0;
    ifc.req_addr_i  = '0;
    ifc.req_write_i = 1'b0;
    ifc.req_size_i  = '0;
    ifc.req_wdata_i = '0;
    ifc.m_hrdata_i  = '0;
    ifc.m_hready_i  = 1'b1;
    ifc.m_hresp_i   = 1'b0;
    doReset();

    $display("[TB] directed: single read, zero waits");
    addRequest(32'h100, 1'b0, 3'd2, 32'h0, 0, 1'b0, 2);
    runUntilIdle(50);

    $display("[TB] directed: write with two wait states");
    addRequest(32'h104, 1'b1, 3'd2, 32'h1234_5678, 2, 1'b0, 4);
    runUntilIdle(50);

    $display("[TB] directed: four back-to-back reads");
    for (int i = 0; i < 4; i++) addRequest(32'(i * 4), 1'b0, 3'd2, 32'h0, 0, 1'b0, 2);
    runUntilIdle(50);

    $display("[TB] directed: error on first of two writes");
    addRequest(32'h400, 1'b1, 3'd2, 32'hCAFE_0001, 0, 1'b1, 3);
    addRequest(32'h404, 1'b1, 3'd2, 32'hCAFE_0002, 0, 1'b0, 3);
    runUntilIdle(50);

    $display("[TB] directed: misaligned halfword then word read");
    addRequest(32'h201, 1'b0, 3'd1, 32'h0, 0, 1'b0, 2);
    addRequest(32'h300, 1'b0, 3'd2, 32'h0, 0, 1'b0, 2);
    runUntilIdle(50);

    $display("[TB] directed: byte read at 0x103 (parity pattern)");
    addRequest(32'h103, 1'b0, 3'd0, 32'h0, 0, 1'b0, 2);
    runUntilIdle(50);

    $display("[TB] random traffic");
    randGaps = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      addRequest(a, 1'($urandom_range(0, 1)), s, $urandom,
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                 ($urandom_range(0, 7) == 0), -1);
    end
    runUntilIdle(5000);
    randGaps = 1'b0;

    $display("[TB] reset in the middle of traffic");
    for (int i = 0; i < 4; i++) addRequest(32'h800 + 32'(i * 4), 1'b0, 3'd2, 32'h0, 2, 1'b0, -1);
    repeat (3) stepCycle();
    doReset();
    addRequest(32'h900, 1'b0, 3'd2, 32'h0, 0, 1'b0, 2);
    runUntilIdle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
